// File: rtl/min_distance_tracker.sv
// rtl/min_distance_tracker.sv - per-frame minimum distance, argmin index and near count over a distance stream
module min_distance_tracker #(
    parameter int DW     = 32,
    parameter int IDXW   = 8,
    parameter int RADIUS = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_dist,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_min,
    output logic [IDXW-1:0] out_idx,
    output logic [IDXW-1:0] out_near,
    output logic            out_ovf
);

    localparam logic [0:0]      ACCUM = 1'b0;
    localparam logic [0:0]      HOLD  = 1'b1;
    localparam logic [DW-1:0]   RAD   = DW'(RADIUS);
    localparam logic [IDXW-1:0] IMAX  = '1;

    logic [0:0]      state;
    logic            active;
    logic [DW-1:0]   min_r;
    logic [IDXW-1:0] idx_r;
    logic [IDXW-1:0] near_r;
    logic [IDXW-1:0] cnt_r;
    logic            ovf_r;

    logic            is_near;
    logic [DW-1:0]   nmin;
    logic [IDXW-1:0] nidx;
    logic [IDXW-1:0] nnear;
    logic [IDXW-1:0] ncnt;
    logic            novf;
    logic            accept;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign is_near   = (in_dist <= RAD);

    // Running values including the beat currently presented
    always_comb begin
        nmin  = in_dist;
        nidx  = '0;
        nnear = IDXW'(is_near);
        novf  = 1'b0;
        ncnt  = cnt_r + 1'b1;
        if (active) begin
            nmin = min_r;
            nidx = idx_r;
            if (in_dist < min_r) begin
                nmin = in_dist;
                nidx = cnt_r;
            end
            nnear = (is_near && (near_r != IMAX)) ? near_r + 1'b1 : near_r;
            // cnt has wrapped to zero mid-frame: this beat is past 2**IDXW candidates
            novf  = ovf_r || (cnt_r == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            active   <= 1'b0;
            min_r    <= '0;
            idx_r    <= '0;
            near_r   <= '0;
            cnt_r    <= '0;
            ovf_r    <= 1'b0;
            out_min  <= '0;
            out_idx  <= '0;
            out_near <= '0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            out_min  <= nmin;
                            out_idx  <= nidx;
                            out_near <= nnear;
                            out_ovf  <= novf;
                            active   <= 1'b0;
                            cnt_r    <= '0;
                            state    <= HOLD;
                        end else begin
                            min_r  <= nmin;
                            idx_r  <= nidx;
                            near_r <= nnear;
                            ovf_r  <= novf;
                            cnt_r  <= ncnt;
                            active <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_distance_tracker.sv
// tb/tb_min_distance_tracker.sv - directed self-checking bench for min_distance_tracker
module tb_min_distance_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [31:0] in_dist, out_min;
    logic [7:0]  out_idx, out_near;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
    logic [31:0] b_in_dist, b_out_min;
    logic [1:0]  b_out_idx, b_out_near;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    min_distance_tracker #(.DW(32), .IDXW(8), .RADIUS(100)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
        .out_idx(out_idx), .out_near(out_near), .out_ovf(out_ovf)
    );

    min_distance_tracker #(.DW(32), .IDXW(2), .RADIUS(100)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dist(b_in_dist), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_min(b_out_min),
        .out_idx(b_out_idx), .out_near(b_out_near), .out_ovf(b_out_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_dist  = d;
        in_last  = last;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("send_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic last);
        int n = 0;
        b_in_valid = 1'b1;
        b_in_dist  = d;
        b_in_last  = last;
        while (!b_in_ready && n < 100) begin
            step();
            n++;
        end
        chk("send_b_ready", b_in_ready, 1);
        step();
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] mn, input logic [7:0] idx,
                                 input logic [7:0] near, input logic ovf);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_min"}, out_min, mn);
        chk({tag, "_idx"}, out_idx, idx);
        chk({tag, "_near"}, out_near, near);
        chk({tag, "_ovf"}, out_ovf, ovf);
    endtask

    task automatic expect_b(input string tag, input logic [31:0] mn, input logic [1:0] idx,
                            input logic [1:0] near, input logic ovf);
        chk({tag, "_valid"}, b_out_valid, 1);
        chk({tag, "_min"}, b_out_min, mn);
        chk({tag, "_idx"}, b_out_idx, idx);
        chk({tag, "_near"}, b_out_near, near);
        chk({tag, "_ovf"}, b_out_ovf, ovf);
        step();
        chk({tag, "_drop"}, b_out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_dist = '0; in_last = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_dist = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_min", out_min, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_near", out_near, 0);
        chk("rst_out_ovf", out_ovf, 0);

        // 1: basic frame, result visible one cycle after last beat, dropped after handshake
        send(5, 0); send(50, 0); send(500, 0); send(800, 0); send(141, 1);
        expect_result("t1", 5, 0, 2, 0);
        step();
        chk("t1_valid_one_cycle", out_valid, 0);
        chk("t1_in_ready_back", in_ready, 1);

        // 2: tie keeps earliest index; all-ones distance is a plain candidate
        send(500, 0); send(141, 0); send(141, 0); send(700, 0); send(32'hFFFF_FFFF, 1);
        expect_result("t2", 141, 1, 0, 0);
        step();

        // 3: single-beat frame exactly at RADIUS
        send(100, 1);
        expect_result("t3", 100, 0, 1, 0);
        step();

        // single-beat frame with maximum distance
        send(32'hFFFF_FFFF, 1);
        expect_result("tmax", 32'hFFFF_FFFF, 0, 0, 0);
        step();

        // 4: backpressure holds result and blocks input
        out_ready = 1'b0;
        send(20, 0); send(10, 1);
        expect_result("t4", 10, 1, 2, 0);
        in_valid = 1'b1; in_dist = 7; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_min", out_min, 10);
            chk("t4_hold_idx", out_idx, 1);
            chk("t4_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk("t4_released", out_valid, 0);
        chk("t4_in_ready_gap", in_ready, 1);
        send(7, 1);
        expect_result("t4b", 7, 0, 1, 0);
        step();

        // 5: reset mid-frame discards partial frame
        send(9, 0); send(8, 0); send(7, 0);
        rst = 1'b1;
        step();
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_min", out_min, 0);
        chk("t5_rst_near", out_near, 0);
        rst = 1'b0;
        chk("t5_rst_in_ready", in_ready, 1);
        send(60, 1);
        expect_result("t5", 60, 0, 1, 0);
        step();

        // 6: IDXW=2 count wrap, overflow and near saturation
        send_b(9, 0); send_b(9, 0); send_b(9, 0); send_b(9, 0); send_b(3, 1);
        expect_b("t6", 3, 0, 3, 1);
        // exactly 2**IDXW candidates does not overflow
        send_b(4, 0); send_b(1, 0); send_b(200, 0); send_b(2, 1);
        expect_b("t6b", 1, 1, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
